// File: rtl/adpll_pkg.sv
// rtl/adpll_pkg.sv - shared types and constants for the ADPLL lock controller
//
// Purpose: FSM state encoding, VCO code limits and a saturating code step helper.
// Ports:   none (package).

package adpll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWEEP  = 2'd1,
    ST_TRACK  = 2'd2,
    ST_LOCKED = 2'd3
  } adpll_state_e;

  localparam logic [3:0] CODE_CENTER = 4'd8;
  localparam logic [3:0] CODE_MIN    = 4'd0;
  localparam logic [3:0] CODE_MAX    = 4'd15;

  // One step up or down; a step that would leave the code range is a no-op.
  function automatic logic [3:0] code_step(input logic [3:0] code, input logic up);
    if (up) begin
      return (code == CODE_MAX) ? code : code + 4'd1;
    end else begin
      return (code == CODE_MIN) ? code : code - 4'd1;
    end
  endfunction

endpackage

// File: rtl/adpll_edge_sync.sv
// rtl/adpll_edge_sync.sv - two-flop synchronizer with registered rising-edge pulse
//
// Purpose: bring an asynchronous clock-like input into the clk domain and emit a
//          one-cycle pulse per rising edge, 3 clk after the input edge.
// Ports:
//   clk       in  system clock
//   reset     in  synchronous, active-low reset
//   din       in  asynchronous input
//   edge_out  out one-cycle rising-edge pulse

module adpll_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic edge_out
);

  // sync_q[0], sync_q[1]: metastability chain; sync_q[2]: previous synced level
  logic [2:0] sync_q, sync_d;
  logic       edge_q, edge_d;

  always_comb begin
    sync_d = {sync_q[1:0], din};
    edge_d = sync_q[1] & ~sync_q[2];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= 3'b000;
      edge_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      edge_q <= edge_d;
    end
  end

  assign edge_out = edge_q;

endmodule

// File: rtl/adpll_lock_ctrl.sv
// rtl/adpll_lock_ctrl.sv - ADPLL coarse sweep and phase-lock supervisor
//
// Purpose: steps a 4-bit VCO code by counting feedback edges per reference
//          period (coarse sweep), then trims it from the TDC phase error and
//          declares / drops lock with hysteresis counters.
// Build option: ADPLL_CTRL_SWEEP_EN enables the coarse sweep (SWEEP state,
//          feedback counter, sweep_fail); without it IDLE goes straight to TRACK.
// Ports:
//   clk        in  system clock (VCO master)
//   reset      in  synchronous, active-low reset
//   enable     in  loop enable; low forces IDLE
//   ref_in     in  asynchronous reference clock
//   fb_in      in  asynchronous divided VCO feedback
//   phase_err  in  signed TDC code
//   code_out   out VCO frequency code
//   code_upd   out one-cycle pulse when code_out changes
//   locked     out lock indicator
//   lock_lost  out one-cycle pulse on LOCKED->TRACK
//   sweep_fail out sticky sweep timeout flag
//   state_out  out current FSM state

module adpll_lock_ctrl
  import adpll_pkg::*;
#(
  parameter int FB_TARGET  = 4,
  parameter int LOCK_WIN   = 1,
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 4,
  parameter int SWEEP_MAX  = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       ref_in,
  input  logic       fb_in,
  input  logic [3:0] phase_err,
  output logic [3:0] code_out,
  output logic       code_upd,
  output logic       locked,
  output logic       lock_lost,
  output logic       sweep_fail,
  output logic [1:0] state_out
);

  logic ref_edge;
  logic fb_edge;

  adpll_edge_sync u_ref_sync (
    .clk      (clk),
    .reset    (reset),
    .din      (ref_in),
    .edge_out (ref_edge)
  );

  adpll_edge_sync u_fb_sync (
    .clk      (clk),
    .reset    (reset),
    .din      (fb_in),
    .edge_out (fb_edge)
  );

  adpll_state_e state_q, state_d;
  logic [3:0]   code_q, code_d;
  logic         code_upd_q, code_upd_d;
  logic         locked_q, locked_d;
  logic         lock_lost_q, lock_lost_d;
  logic         sweep_fail_q, sweep_fail_d;
  logic [7:0]   lock_cnt_q, lock_cnt_d;
  logic [7:0]   unlock_cnt_q, unlock_cnt_d;

  // |phase_err|; -8 maps to 4'b1000 which reads as 8 unsigned.
  logic [3:0] err_abs;
  logic       err_out;
  assign err_abs = phase_err[3] ? (4'd0 - phase_err) : phase_err;
  assign err_out = int'(err_abs) > LOCK_WIN;

`ifdef ADPLL_CTRL_SWEEP_EN
  logic [7:0] fb_cnt_q, fb_cnt_d;
  logic [7:0] per_cnt_q, per_cnt_d;
  logic       win_open_q, win_open_d;
  logic [7:0] fb_close;

  // Closing count includes an fb edge coincident with the ref edge.
  assign fb_close = (fb_edge && (fb_cnt_q != 8'hFF)) ? fb_cnt_q + 8'd1 : fb_cnt_q;
`else
  logic [7:0] cfg_unused;
  assign cfg_unused = 8'(FB_TARGET) ^ 8'(SWEEP_MAX) ^ {7'd0, fb_edge};
`endif

  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    locked_d     = locked_q;
    lock_lost_d  = 1'b0;
    sweep_fail_d = sweep_fail_q;
    lock_cnt_d   = lock_cnt_q;
    unlock_cnt_d = unlock_cnt_q;
`ifdef ADPLL_CTRL_SWEEP_EN
    fb_cnt_d     = fb_cnt_q;
    per_cnt_d    = per_cnt_q;
    win_open_d   = win_open_q;
`endif

    if (!enable) begin
      // sweep_fail is deliberately kept so software can still read it.
      state_d      = ST_IDLE;
      code_d       = CODE_CENTER;
      locked_d     = 1'b0;
      lock_cnt_d   = 8'd0;
      unlock_cnt_d = 8'd0;
`ifdef ADPLL_CTRL_SWEEP_EN
      fb_cnt_d     = 8'd0;
      per_cnt_d    = 8'd0;
      win_open_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          code_d = CODE_CENTER;
          if (ref_edge) begin
`ifdef ADPLL_CTRL_SWEEP_EN
            state_d = ST_SWEEP;
`else
            state_d = ST_TRACK;
`endif
          end
        end

`ifdef ADPLL_CTRL_SWEEP_EN
        ST_SWEEP: begin
          fb_cnt_d = fb_close;
          if (ref_edge) begin
            fb_cnt_d = 8'd0;
            if (!win_open_q) begin
              // The first edge only starts a clean counting window.
              win_open_d = 1'b1;
            end else if (int'(fb_close) == FB_TARGET) begin
              state_d = ST_TRACK;
            end else begin
              code_d    = code_step(code_q, int'(fb_close) < FB_TARGET);
              per_cnt_d = per_cnt_q + 8'd1;
              if (int'(per_cnt_q) + 1 >= SWEEP_MAX) begin
                sweep_fail_d = 1'b1;
                state_d      = ST_TRACK;
              end
            end
          end
        end
`endif

        ST_TRACK: begin
          if (ref_edge) begin
            if (err_out) begin
              code_d     = code_step(code_q, ~phase_err[3]);
              lock_cnt_d = 8'd0;
            end else if (int'(lock_cnt_q) + 1 >= LOCK_CNT) begin
              state_d      = ST_LOCKED;
              locked_d     = 1'b1;
              lock_cnt_d   = 8'd0;
              unlock_cnt_d = 8'd0;
            end else begin
              lock_cnt_d = lock_cnt_q + 8'd1;
            end
          end
        end

        ST_LOCKED: begin
          if (ref_edge) begin
            if (!err_out) begin
              unlock_cnt_d = 8'd0;
            end else if (int'(unlock_cnt_q) + 1 >= UNLOCK_CNT) begin
              state_d      = ST_TRACK;
              locked_d     = 1'b0;
              lock_lost_d  = 1'b1;
              lock_cnt_d   = 8'd0;
              unlock_cnt_d = 8'd0;
            end else begin
              unlock_cnt_d = unlock_cnt_q + 8'd1;
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end

    // Registered alongside the code so the pulse coincides with the new value.
    code_upd_d = (code_d != code_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      code_q       <= CODE_CENTER;
      code_upd_q   <= 1'b0;
      locked_q     <= 1'b0;
      lock_lost_q  <= 1'b0;
      sweep_fail_q <= 1'b0;
      lock_cnt_q   <= 8'd0;
      unlock_cnt_q <= 8'd0;
`ifdef ADPLL_CTRL_SWEEP_EN
      fb_cnt_q     <= 8'd0;
      per_cnt_q    <= 8'd0;
      win_open_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      code_upd_q   <= code_upd_d;
      locked_q     <= locked_d;
      lock_lost_q  <= lock_lost_d;
      sweep_fail_q <= sweep_fail_d;
      lock_cnt_q   <= lock_cnt_d;
      unlock_cnt_q <= unlock_cnt_d;
`ifdef ADPLL_CTRL_SWEEP_EN
      fb_cnt_q     <= fb_cnt_d;
      per_cnt_q    <= per_cnt_d;
      win_open_q   <= win_open_d;
`endif
    end
  end

  assign code_out   = code_q;
  assign code_upd   = code_upd_q;
  assign locked     = locked_q;
  assign lock_lost  = lock_lost_q;
  assign sweep_fail = sweep_fail_q;
  assign state_out  = state_q;

endmodule

// File: doc/adpll_lock_ctrl.md
ADPLL_LOCK_CTRL -- requirements
Module: adpll_lock_ctrl

Interface
REQ-001 The block SHALL use parameter FB_TARGET, default 4, as the expected feedback rising edges per reference period.
REQ-002 The block SHALL use parameter LOCK_WIN, default 1, as the maximum |phase error| that counts as in-window.
REQ-003 The block SHALL use parameter LOCK_CNT, default 8, as the number of consecutive in-window reference periods needed to declare lock.
REQ-004 The block SHALL use parameter UNLOCK_CNT, default 4, as the number of consecutive out-of-window periods needed to drop lock.
REQ-005 The block SHALL use parameter SWEEP_MAX, default 32, as the reference-period limit for the coarse sweep.
REQ-006 The block SHALL have these ports:
- clk  in  1  system clock (VCO master clock)
- reset  in  1  reset, synchronous, active-low; clock clk
- enable  in  1  loop enable; low forces IDLE
- ref_in  in  1  asynchronous reference clock (2.5 kHz)
- fb_in  in  1  asynchronous divided VCO feedback
- phase_err  in  4  signed TDC encoder code (two's complement)
- code_out  out  4  VCO frequency code
- code_upd  out  1  one-cycle pulse whenever code_out changes
- locked  out  1  lock indicator
- lock_lost  out  1  one-cycle pulse on LOCKED->TRACK
- sweep_fail  out  1  sticky flag: sweep hit SWEEP_MAX
- state_out  out  2  current state encoding

Function
REQ-007 ref_in and fb_in SHALL each pass a 2-flop synchronizer plus rising-edge detector, giving ref_edge/fb_edge pulses 3 clk after the input edge.
REQ-008 The FSM SHALL have states IDLE=0, SWEEP=1, TRACK=2, LOCKED=3, driven on state_out.
REQ-009 IDLE: code_out SHALL hold 8; on the first ref_edge with enable=1, go to SWEEP.
REQ-010 SWEEP: an 8-bit counter SHALL count fb_edge, saturate at 255, and clear on each ref_edge.
REQ-011 SWEEP: at each ref_edge the closing count SHALL be compared with FB_TARGET: below -> code+1, above -> code-1, equal -> TRACK with code unchanged.
REQ-012 SWEEP: code SHALL saturate at 0 and 15; a saturating step SHALL leave code unchanged.
REQ-013 SWEEP: the first ref_edge after entry SHALL only open the window, with no comparison.
REQ-014 SWEEP: when the period counter reaches SWEEP_MAX, the block SHALL set sweep_fail and go to TRACK with the current code.
REQ-015 If ref_edge and fb_edge fall in the same cycle, fb_edge SHALL count toward the closing period.
REQ-016 TRACK: phase_err SHALL be sampled at each ref_edge; |err|>LOCK_WIN -> code moves ±1 in the sign of err (saturating) and the lock counter clears; else the lock counter increments.
REQ-017 TRACK: the lock counter reaching LOCK_CNT SHALL cause LOCKED and locked=1 on the next cycle.
REQ-018 The value -8 SHALL be treated as |err|=8.
REQ-019 LOCKED: code_out SHALL be frozen; an out-of-window sample increments the unlock counter and an in-window sample clears it.
REQ-020 LOCKED: the unlock counter reaching UNLOCK_CNT SHALL cause TRACK, locked=0, a lock_lost pulse, and both counters cleared.
REQ-021 enable=0 in any state SHALL cause IDLE next cycle with code_out=8, counters cleared, and sweep_fail retained.
REQ-022 code_upd SHALL pulse the cycle after any code_out change, including a forced return to 8.

Reset
REQ-023 reset=0 sampled on a clk edge SHALL give: state IDLE, code_out=8, locked=0, lock_lost=0, code_upd=0, sweep_fail=0, all counters and synchronizers 0.
REQ-024 Reset mid-operation SHALL take priority over all FSM activity on that same edge.

Configuration
REQ-025 With ADPLL_CTRL_SWEEP_EN defined, the SWEEP state, fb counter and sweep_fail logic SHALL be present.
REQ-026 Without ADPLL_CTRL_SWEEP_EN, IDLE SHALL go directly to TRACK at code 8, sweep_fail SHALL tie to 0, fb_in SHALL be unused, and state encoding SHALL be unchanged.

Structure
REQ-027 Package adpll_pkg SHALL hold the state enum, CODE_CENTER=4'd8, CODE_MIN and CODE_MAX.
REQ-028 Sub-module adpll_edge_sync (synchronizer plus rising-edge detect) SHALL be instantiated twice.

Verification
REQ-029 Scenario: reset, enable=1, fb at 6 edges/period -> SWEEP steps code 8->7->6 ... until the count reaches 4, then TRACK.
REQ-030 Scenario: fb at 0 edges/period -> code climbs to 15 and holds; sweep_fail=1 after 32 periods; then TRACK.
REQ-031 Scenario: TRACK with phase_err=0 for 8 periods -> locked=1 after the 8th ref_edge; code unchanged.
REQ-032 Scenario: LOCKED, phase_err=+3 for 4 periods -> one lock_lost pulse, state TRACK, code+1 on the next +3 sample.
REQ-033 Scenario: phase_err=-8 in TRACK at code 0 -> code stays 0 and no code_upd pulse.
REQ-034 Scenario: enable dropped while LOCKED at code 11 -> next cycle IDLE, code_out=8, code_upd pulse, locked=0.
